// File: rtl/pll_phase_ctrl_pkg.sv
// Shared definitions for the PF_CCC PLL sequencer: state encoding, REQ_SEL bit
// positions and small state-class helpers.
package pll_phase_ctrl_pkg;

  typedef logic [2:0] state_t;

  // IDLE and every request state encode at or above ST_IDLE.
  localparam state_t ST_PWRDN     = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_FAIL      = 3'd2;
  localparam state_t ST_IDLE      = 3'd3;
  localparam state_t ST_SETUP     = 3'd4;
  localparam state_t ST_ROT_HI    = 3'd5;
  localparam state_t ST_ROT_LO    = 3'd6;
  localparam state_t ST_LOAD      = 3'd7;

  localparam int SEL_OUT0 = 0;
  localparam int SEL_OUT2 = 1;
  localparam int SEL_OUT3 = 2;

  function automatic logic st_locked(input state_t st);
    return st >= ST_IDLE;
  endfunction

  function automatic logic st_busy(input state_t st);
    return st >= ST_SETUP;
  endfunction

endpackage

// File: rtl/pll_lock_qual.sv
// PLL lock synchronizer plus a run-length qualifier; the run only advances
// while enabled, so the sequencer controls when a lock attempt is counted.
module pll_lock_qual
  #(parameter int LOCK_STABLE = 256)
  (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic lock_i,
    output logic lock_s_o,
    output logic lock_ok_o
  );

  localparam int RUN_W = $clog2(LOCK_STABLE + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_STABLE - 1);

  logic             sync1_q, sync2_q;
  logic [RUN_W-1:0] run_q, run_d;

  always_comb begin
    run_d = '0;
    if (en_i && sync2_q)
      run_d = (run_q == RUN_LAST) ? run_q : run_q + RUN_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= lock_i;
      sync2_q <= sync1_q;
      run_q   <= run_d;
    end
  end

  assign lock_s_o  = sync2_q;
  assign lock_ok_o = en_i && sync2_q && (run_q == RUN_LAST);

endmodule

// File: rtl/pll_phase_ctrl.sv
// PF_CCC PLL sequencer: power-up, lock qualification, dynamic phase stepping
// with per-output phase tracking and automatic relock on lock loss.
module pll_phase_ctrl
  import pll_phase_ctrl_pkg::*;
  #(
    parameter int PD_CYCLES    = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 256,
    parameter int ROT_HI       = 2,
    parameter int ROT_LO       = 2,
    parameter int LOAD_CYCLES  = 2,
    parameter int STEP_W       = 6,
    parameter int PHASE_W      = 6
  )
  (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               REQ_VALID,
    output logic               REQ_READY,
    input  logic [2:0]         REQ_SEL,
    input  logic               REQ_DIR,
    input  logic [STEP_W-1:0]  REQ_STEPS,
    output logic               DONE,
    output logic               BUSY,
    output logic               PLL_READY,
    output logic               LOCK_ERR,
    output logic [7:0]         RELOCK_CNT,
    output logic [PHASE_W-1:0] PHASE0,
    output logic [PHASE_W-1:0] PHASE2,
    output logic [PHASE_W-1:0] PHASE3,
    input  logic               PLL_LOCK_0,
    output logic               PLL_POWERDOWN_N_0,
    output logic               PHASE_OUT0_SEL_0,
    output logic               PHASE_OUT2_SEL_0,
    output logic               PHASE_OUT3_SEL_0,
    output logic               PHASE_DIRECTION_0,
    output logic               PHASE_ROTATE_0,
    output logic               LOAD_PHASE_N_0
  );

  localparam int CNT_W = $clog2(PD_CYCLES + LOCK_TIMEOUT + ROT_HI + ROT_LO + LOAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(ROT_HI - 1);
  localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(ROT_LO - 1);
  localparam logic [CNT_W-1:0] LD_LAST = CNT_W'(LOAD_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [STEP_W-1:0]       steps_q, steps_d;
  logic [2:0]              sel_q, sel_d;
  logic                    dir_q, dir_d;
  logic [2:0][PHASE_W-1:0] ph_q, ph_d;
  logic                    err_q, err_d;
  logic [7:0]              relock_q, relock_d;
  logic                    done_d;
  logic                    lock_s, lock_ok, lost;

  logic       pd_n_q, rot_q, load_n_q, dir_pin_q;
  logic [2:0] sel_pin_q;
  logic       ready_q, done_q, busy_q, pll_ready_q;

  pll_lock_qual #(.LOCK_STABLE(LOCK_STABLE)) u_lock_qual (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .en_i     (state_q == ST_WAIT_LOCK),
    .lock_i   (PLL_LOCK_0),
    .lock_s_o (lock_s),
    .lock_ok_o(lock_ok)
  );

  assign lost = st_locked(state_q) && !lock_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    steps_d  = steps_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    ph_d     = ph_q;
    err_d    = err_q;
    relock_d = relock_q;
    done_d   = 1'b0;

    case (state_q)
      ST_PWRDN:
        if (cnt_q == PD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      ST_WAIT_LOCK:
        if (lock_ok) begin
          // A fresh lock restarts the PLL output phases from zero.
          state_d = ST_IDLE;
          cnt_d   = '0;
          ph_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAIL;
          cnt_d   = '0;
        end
      ST_FAIL: begin
        state_d = ST_PWRDN;
        cnt_d   = '0;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (REQ_VALID) begin
          sel_d   = REQ_SEL;
          dir_d   = REQ_DIR;
          steps_d = REQ_STEPS;
          if (REQ_STEPS == '0 || REQ_SEL == 3'b000) done_d  = 1'b1;
          else                                       state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ROT_HI;
        cnt_d   = '0;
      end
      ST_ROT_HI:
        if (cnt_q == RH_LAST) begin
          state_d = ST_ROT_LO;
          cnt_d   = '0;
        end
      ST_ROT_LO:
        if (cnt_q == RL_LAST) begin
          cnt_d = '0;
          if (steps_q == STEP_W'(1)) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_ROT_HI;
            steps_d = steps_q - STEP_W'(1);
          end
        end
      ST_LOAD:
        if (cnt_q == LD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      default: begin
        state_d = ST_PWRDN;
        cnt_d   = '0;
      end
    endcase

    if (lost) begin
      state_d = ST_PWRDN;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    if (lost || state_d == ST_FAIL) begin
      err_d = 1'b1;
      if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
    end

    if (state_d == ST_ROT_HI && state_q != ST_ROT_HI) begin
      for (int i = 0; i < 3; i++)
        if (sel_q[i]) ph_d[i] = dir_q ? ph_q[i] + PHASE_W'(1) : ph_q[i] - PHASE_W'(1);
    end
  end

  // Pins are registered from the next state so they never see inputs combinationally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_PWRDN;
      cnt_q       <= '0;
      steps_q     <= '0;
      sel_q       <= '0;
      dir_q       <= 1'b0;
      ph_q        <= '0;
      err_q       <= 1'b0;
      relock_q    <= '0;
      pd_n_q      <= 1'b0;
      rot_q       <= 1'b0;
      load_n_q    <= 1'b1;
      sel_pin_q   <= '0;
      dir_pin_q   <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      pll_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      steps_q     <= steps_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      ph_q        <= ph_d;
      err_q       <= err_d;
      relock_q    <= relock_d;
      pd_n_q      <= state_d != ST_PWRDN;
      rot_q       <= state_d == ST_ROT_HI;
      load_n_q    <= state_d != ST_LOAD;
      sel_pin_q   <= st_busy(state_d) ? sel_d : 3'b000;
      dir_pin_q   <= st_busy(state_d) && dir_d;
      ready_q     <= state_d == ST_IDLE;
      done_q      <= done_d;
      busy_q      <= st_busy(state_d);
      pll_ready_q <= st_locked(state_d);
    end
  end

  assign REQ_READY         = ready_q;
  assign DONE              = done_q;
  assign BUSY              = busy_q;
  assign PLL_READY         = pll_ready_q;
  assign LOCK_ERR          = err_q;
  assign RELOCK_CNT        = relock_q;
  assign PHASE0            = ph_q[SEL_OUT0];
  assign PHASE2            = ph_q[SEL_OUT2];
  assign PHASE3            = ph_q[SEL_OUT3];
  assign PLL_POWERDOWN_N_0 = pd_n_q;
  assign PHASE_OUT0_SEL_0  = sel_pin_q[SEL_OUT0];
  assign PHASE_OUT2_SEL_0  = sel_pin_q[SEL_OUT2];
  assign PHASE_OUT3_SEL_0  = sel_pin_q[SEL_OUT3];
  assign PHASE_DIRECTION_0 = dir_pin_q;
  assign PHASE_ROTATE_0    = rot_q;
  assign LOAD_PHASE_N_0    = load_n_q;

endmodule
